// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the SAR conversion controller.
//   SAR_WIDTH_DEFAULT : default conversion resolution in bits.
//   state_t           : FSM state encoding. The SETTLE state exists only
//                       when SAR_CTRL_SETTLE_EN is defined.
package sar_pkg;

    localparam int unsigned SAR_WIDTH_DEFAULT = 7;

`ifdef SAR_CTRL_SETTLE_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`endif

endpackage : sar_pkg

// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation ADC controller.
// Drives a trial code to an external comparator, resolves one bit per
// WAIT/DECIDE pair (MSB first) and reports the final code.
// Optional feature: define SAR_CTRL_SETTLE_EN to insert a one-cycle SETTLE
// state after every WAIT (latency 3*WIDTH instead of 2*WIDTH).
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous active-high reset
//   start    in  : conversion request, sampled only in IDLE
//   cmp      in  : registered comparator bit (1: trial code >= input),
//                  one clock behind dac_code
//   dac_code out : trial code to the comparator
//   busy     out : conversion in progress
//   done     out : one-cycle pulse, result valid
//   result   out : last completed conversion
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned     PTR_W   = $clog2(WIDTH);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] trial;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        result_d = result_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        trial    = dac_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dac_d   = MSB_CODE;
                    ptr_d   = PTR_TOP;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            // cmp still reflects the previous trial code here.
            ST_WAIT: begin
`ifdef SAR_CTRL_SETTLE_EN
                state_d = ST_SETTLE;
`else
                state_d = ST_DECIDE;
`endif
            end

`ifdef SAR_CTRL_SETTLE_EN
            ST_SETTLE: begin
                state_d = ST_DECIDE;
            end
`endif

            ST_DECIDE: begin
                // Trial too high (or equal): drop the bit under test.
                if (cmp) begin
                    trial[ptr_q] = 1'b0;
                end
                if (ptr_q == '0) begin
                    dac_d    = trial;
                    result_d = trial;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    trial[ptr_q - 1'b1] = 1'b1;
                    dac_d   = trial;
                    ptr_d   = ptr_q - 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dac_q    <= '0;
            result_q <= '0;
            ptr_q    <= PTR_TOP;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule : sar_ctrl
